// File: rtl/offchip_buf_arbiter.sv
// offchip_buf_arbiter: credit-gated round-robin arbiter feeding the off-chip byte serializer.
// Define OFFCHIP_ARB_STRICT_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module offchip_buf_arbiter #(
    parameter int DEPTH            = 8,
    parameter int ENTRIES_PER_BYTE = 2,
    parameter int CREDIT_CHUNK     = 4,
    parameter int CNT_W            = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [7:0]       data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [7:0]       data1,
    output logic             gnt1,
    output logic             ser_valid,
    output logic [7:0]       ser_data,
    output logic             ser_src,
    input  logic             ser_ready,
    input  logic             credit_ret,
    output logic [CNT_W-1:0] credits,
    output logic             cred_err
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] CHUNK_W = (CNT_W+1)'(CREDIT_CHUNK);
    localparam logic [CNT_W:0] EPB_W   = (CNT_W+1)'(ENTRIES_PER_BYTE);

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             src_q, src_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             cred_err_q, cred_err_d;
    logic             sel, eligible, handshake, capture;
    logic [CNT_W:0]   cred_sum;

    always_comb begin
`ifdef OFFCHIP_ARB_STRICT_PRIO_EN
        sel = req1 & ~req0;
`else
        sel = (req0 & req1) ? ~last_q : req1;
`endif
        eligible = ({1'b0, credits_q} >= EPB_W) & (req0 | req1);
        handshake = (state_q == SEND) & valid_q & ser_ready;
        capture = eligible & ((state_q == IDLE) | handshake);
        // One extra bit so an over-return is visible before clamping
        cred_sum = {1'b0, credits_q} + (credit_ret ? CHUNK_W : '0) - (capture ? EPB_W : '0);
        state_d = capture ? SEND : (handshake ? IDLE : state_q);
        valid_d = capture | (valid_q & ~handshake);
        data_d = capture ? (sel ? data1 : data0) : data_q;
        src_d = capture ? sel : src_q;
        last_d = capture ? sel : last_q;
        credits_d = (cred_sum > DEPTH_W) ? DEPTH_W[CNT_W-1:0] : cred_sum[CNT_W-1:0];
        cred_err_d = cred_err_q | (cred_sum > DEPTH_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            src_q      <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b1;
            credits_q  <= DEPTH_W[CNT_W-1:0];
            cred_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            src_q      <= src_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            credits_q  <= credits_d;
            cred_err_q <= cred_err_d;
        end
    end

    assign gnt0      = capture & ~sel & ~rst;
    assign gnt1      = capture & sel & ~rst;
    assign ser_valid = valid_q;
    assign ser_data  = data_q;
    assign ser_src   = src_q;
    assign credits   = credits_q;
    assign cred_err  = cred_err_q;
endmodule

// File: tb/tb_offchip_buf_arbiter.sv
// tb_offchip_buf_arbiter: directed stimulus with a per-cycle reference model plus literal spot checks.
module tb_offchip_buf_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, ser_ready = 1'b0, credit_ret = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, ser_valid, ser_src, cred_err;
    logic [7:0] ser_data;
    logic [3:0] credits;

    int passed = 0;
    int total  = 0;

    offchip_buf_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_src(ser_src), .ser_ready(ser_ready),
        .credit_ret(credit_ret), .credits(credits), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference model: one slot in flight toward the serializer, plus a free-entry count.
    int       m_cred  = 8;
    bit       m_err   = 0;
    bit       m_valid = 0;
    bit [7:0] m_data  = 0;
    bit       m_src   = 0;
    bit       m_last  = 1;

    function automatic bit m_sel();
`ifdef OFFCHIP_ARB_STRICT_PRIO_EN
        return req1 && !req0;
`else
        if (req0 && req1) return !m_last;
        return req1;
`endif
    endfunction

    function automatic bit m_cap();
        return (m_cred >= 2) && (req0 || req1) && (!m_valid || ser_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cred = 8; m_err = 0; m_valid = 0; m_data = 0; m_src = 0; m_last = 1;
        end else begin
            automatic bit cap = m_cap();
            automatic bit s   = m_sel();
            automatic int nc  = m_cred + (credit_ret ? 4 : 0) - (cap ? 2 : 0);
            if (nc > 8) begin nc = 8; m_err = 1; end
            m_cred = nc;
            if (cap) begin
                m_valid = 1; m_data = s ? data1 : data0; m_src = s; m_last = s;
            end else if (m_valid && ser_ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        automatic bit cap = !rst && m_cap();
        automatic bit s   = m_sel();
        chk("m_gnt0", gnt0, cap && !s);
        chk("m_gnt1", gnt1, cap && s);
        chk("m_ser_valid", ser_valid, m_valid);
        if (m_valid) begin
            chk("m_ser_data", ser_data, m_data);
            chk("m_ser_src", ser_src, m_src);
        end
        chk("m_credits", credits, m_cred);
        chk("m_cred_err", cred_err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 0; req1 = 0; credit_ret = 0; ser_ready = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", ser_valid, 0);
        chk("rst_credits", credits, 8);
        chk("rst_err", cred_err, 0);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);

        req0 = 1; data0 = 8'hA5; ser_ready = 1;
        #1 chk("first_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 0;
        chk("first_valid", ser_valid, 1);
        chk("first_data", ser_data, 8'hA5);
        chk("first_src", ser_src, 0);
        chk("first_credits", credits, 6);
        tick();
        chk("first_drain", ser_valid, 0);

        req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
        for (int i = 0; i < 6; i++) begin
            credit_ret = (i % 2 == 0);
            #1;
`ifdef OFFCHIP_ARB_STRICT_PRIO_EN
            chk("alt_gnt", {gnt1, gnt0}, 2'b01);
`else
            chk("alt_gnt", {gnt1, gnt0}, (i % 2 == 0) ? 2'b10 : 2'b01);
`endif
            tick();
        end
        req0 = 0; req1 = 0; credit_ret = 0;
        chk("alt_data", ser_data, 8'h11);
        chk("alt_credits", credits, 6);
        tick();

        do_reset();
        req0 = 1; ser_ready = 1;
        for (int i = 0; i < 4; i++) begin
            data0 = 8'(i + 1);
            #1 chk("exh_gnt", gnt0, 1);
            tick();
        end
        chk("exh_credits", credits, 0);
        chk("exh_last_data", ser_data, 8'h04);
        #1 chk("exh_no_gnt", gnt0, 0);
        tick();
        chk("exh_idle", ser_valid, 0);
        credit_ret = 1;
        #1 chk("ret_same_cycle_no_gnt", gnt0, 0);
        tick();
        credit_ret = 0;
        chk("ret_credits", credits, 4);
        data0 = 8'h3C;
        #1 chk("ret_gnt", gnt0, 1);
        tick();
        chk("ret_after_cap", credits, 2);

        credit_ret = 1;
        #1 chk("both_gnt", gnt0, 1);
        tick();
        req0 = 0; credit_ret = 0;
        chk("both_credits", credits, 4);
        tick();

        do_reset();
        credit_ret = 1;
        tick();
        credit_ret = 0;
        chk("over_credits", credits, 8);
        chk("over_err", cred_err, 1);
        tick();
        chk("over_sticky", cred_err, 1);

        do_reset();
        chk("err_cleared", cred_err, 0);
        req0 = 1; data0 = 8'h5A; ser_ready = 0;
        tick();
        req0 = 1; req1 = 1; data0 = 8'hFF; data1 = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_gnt", {gnt1, gnt0}, 2'b00);
            chk("stall_data", ser_data, 8'h5A);
            chk("stall_valid", ser_valid, 1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_valid", ser_valid, 0);
        chk("midrst_credits", credits, 8);
        chk("midrst_gnt", {gnt1, gnt0}, 2'b00);
        tick();
        req0 = 0; req1 = 0;
        rst = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/offchip_buf_arbiter.md
Name: offchip_buf_arbiter

Overview:
Credit-based arbiter and sequencer in front of the off-chip byte serializer and its shared 8-entry nibble buffer. Two upstream byte requesters compete for the serializer. The block grants one requester at a time (round-robin) and forwards the byte with a valid/ready handshake. It admits a byte only when the buffer has room for its entries, and tracks free entries via credit-return pulses from the read side.

Parameters:
DEPTH, 8, buffer entries available; credit counter reset value
ENTRIES_PER_BYTE, 2, buffer entries consumed per accepted byte
CREDIT_CHUNK, 4, entries returned per credit_ret pulse
CNT_W, 4, credit counter width; must hold DEPTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 has a byte; held with data0 until gnt0
data0  in  8  requester 0 byte
gnt0  out  1  combinational; byte on data0 captured this cycle
req1  in  1  requester 1 has a byte
data1  in  8  requester 1 byte
gnt1  out  1  combinational; byte on data1 captured this cycle
ser_valid  out  1  byte valid toward serializer
ser_data  out  8  byte toward serializer
ser_src  out  1  requester index of ser_data
ser_ready  in  1  serializer accepts when ser_valid & ser_ready
credit_ret  in  1  pulse: CREDIT_CHUNK entries freed by read side
credits  out  CNT_W  current free-entry count
cred_err  out  1  sticky: credit return would exceed DEPTH

Behaviour:
- Reset (async, immediate): state=IDLE, ser_valid=0, ser_data=0, ser_src=0, credits=DEPTH, cred_err=0, last=1 (requester 0 wins the first tie). gnt0/gnt1=0 while rst is high.
- eligible = (credits >= ENTRIES_PER_BYTE) & (req0 | req1). Uses the registered credits; a same-cycle credit_ret does not count.
- Selection: if only one req, select it. If both, select !last (round-robin).
- capture = eligible & (state==IDLE | (state==SEND & ser_valid & ser_ready)).
- gntN = capture & (sel==N). Exactly one gnt per captured byte, never both.
- FSM states:
  - IDLE: on capture → SEND; ser_data<=data_sel, ser_src<=sel, ser_valid<=1, last<=sel. Otherwise stay.
  - SEND: ser_valid, ser_data and ser_src held stable until the handshake. On handshake with capture, reload the new byte and stay in SEND (back-to-back, 1 byte/cycle). On handshake without capture → IDLE, ser_valid<=0. Without a handshake, stay.
- Latency: req with credit available → ser_valid 1 cycle later. gnt is in the same cycle as req.
- Credit update per cycle: credits_next = credits + (credit_ret ? CREDIT_CHUNK : 0) − (capture ? ENTRIES_PER_BYTE : 0). Simultaneous return and consume are both applied.
- If credits_next > DEPTH: clamp credits to DEPTH and set cred_err=1. cred_err stays set until reset.
- credits never underflows, because capture requires credits >= ENTRIES_PER_BYTE.
- Requester dropping req without a gnt is legal; that requester is not selected.
- Reset asserted mid-SEND drops the in-flight byte: ser_valid goes low immediately and credits returns to DEPTH.

Optional Feature:
OFFCHIP_ARB_STRICT_PRIO_EN:
- Defined: requester 0 always wins when both request; last is not used for selection.
- Undefined: round-robin as above.
Credit, FSM and handshake behaviour are identical in both builds.

Test Plan:
- Reset, then idle → ser_valid=0, credits=8, cred_err=0, gnt0=gnt1=0.
- req0=1, data0=0xA5, ser_ready=1 → gnt0 same cycle. Next cycle ser_valid=1, ser_data=0xA5, ser_src=0, credits=6.
- req0 and req1 held high, ser_ready=1, credit_ret pulsed often enough → grants alternate 0,1,0,1, one byte per cycle after the first.
- No credit_ret, requests continuous → 4 bytes accepted (credits 8→0). The 5th request is not granted. One credit_ret pulse → credits=4 and the next grant follows.
- credits=2 with capture and credit_ret in the same cycle → credits=4. At credits=8, credit_ret → credits stays 8 and cred_err=1.
- ser_ready=0 for 5 cycles during SEND → ser_data stable, no gnt. Assert rst mid-stall → ser_valid=0 immediately and credits=8.
